// File: rtl/eb_pkg.sv
// Shared types and helpers for the elastic buffer (write and read sides).
// Holds the ordered-set FSM state enum, default COM/SKP symbol constants,
// and Gray/binary conversion functions sized to EB_PTR_MAX_W.
package eb_pkg;

  localparam int unsigned EB_SYM_W     = 10;
  localparam int unsigned EB_PTR_MAX_W = 16;

  // COM and SKP in both running disparities
  localparam logic [EB_SYM_W-1:0] EB_COM_P = 10'b001111_1010;
  localparam logic [EB_SYM_W-1:0] EB_COM_N = 10'b110000_0101;
  localparam logic [EB_SYM_W-1:0] EB_SKP_P = 10'b001111_1001;
  localparam logic [EB_SYM_W-1:0] EB_SKP_N = 10'b110000_0110;

  // Ordered-set tracking: NORMAL = data stream, OS_OPEN = COM seen and a
  // SKP may still be deleted, OS_DONE = this ordered set already lost a SKP.
  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    OS_OPEN = 2'd1,
    OS_DONE = 2'd2
  } eb_os_state_e;

  function automatic logic [EB_PTR_MAX_W-1:0] bin2gray(input logic [EB_PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended inputs convert correctly.
  function automatic logic [EB_PTR_MAX_W-1:0] gray2bin(input logic [EB_PTR_MAX_W-1:0] g);
    logic [EB_PTR_MAX_W-1:0] b;
    b = g;
    for (int s = 1; s < int'(EB_PTR_MAX_W); s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/elastic_write_ctrl_if.sv
// Write-side bundle of the elastic buffer.
// master: symbol source / read-side pointer / control (drives inputs).
// slave : elastic_write_ctrl (drives write strobe, pointers, status).
interface elastic_write_ctrl_if #(
  parameter int unsigned DATA_WIDTH   = 10,
  parameter int unsigned BUFFER_DEPTH = 16
);
  localparam int unsigned PW = $clog2(BUFFER_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  delete_req;
  logic [PW-1:0]         gray_read_pointer;
  logic                  overflow_clr;

  logic                  write_en;
  logic [PW-1:0]         write_address;
  logic [PW-1:0]         gray_write_pointer;
  logic [PW-1:0]         fill_level;
  logic                  full;
  logic                  overflow;
  logic                  skp_removed;
  logic                  skp_added;

  modport master (
    output data_in, data_valid, delete_req, gray_read_pointer, overflow_clr,
    input  write_en, write_address, gray_write_pointer, fill_level,
           full, overflow, skp_removed, skp_added
  );

  modport slave (
    input  data_in, data_valid, delete_req, gray_read_pointer, overflow_clr,
    output write_en, write_address, gray_write_pointer, fill_level,
           full, overflow, skp_removed, skp_added
  );

endinterface

// File: rtl/eb_bin2gray.sv
// Binary to Gray pointer encoder, shared by the write and read sides.
// Ports: bin_i (binary pointer), gray_o (Gray-coded pointer, combinational).
module eb_bin2gray #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] bin_i,
  output logic [W-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/elastic_write_ctrl.sv
// Write-side controller of a clock-compensation elastic buffer.
// Generates the buffer write strobe and pointers, tracks occupancy against
// the synchronised read pointer, deletes at most one SKP per ordered set,
// and flags overflow / SKP add opportunities.
// Ports: write_clk, rst_n (async, active-low), eb (elastic_write_ctrl_if.slave):
//   in : data_in, data_valid, delete_req, gray_read_pointer, overflow_clr
//   out: write_en, full, gray_write_pointer (combinational);
//        write_address, fill_level, overflow, skp_removed, skp_added (registered)
// Build option: EB_AUTO_DELETE_EN selects fill-level driven SKP deletion
// (fill_level >= HIGH_WM) instead of delete_req.
module elastic_write_ctrl
  import eb_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 10,
  parameter int unsigned           BUFFER_DEPTH = 16,
  parameter logic [DATA_WIDTH-1:0] COM_P        = DATA_WIDTH'(EB_COM_P),
  parameter logic [DATA_WIDTH-1:0] COM_N        = DATA_WIDTH'(EB_COM_N),
  parameter logic [DATA_WIDTH-1:0] SKP_P        = DATA_WIDTH'(EB_SKP_P),
  parameter logic [DATA_WIDTH-1:0] SKP_N        = DATA_WIDTH'(EB_SKP_N),
  parameter int unsigned           HIGH_WM      = 12,
  parameter int unsigned           LOW_WM       = 4
) (
  input logic           write_clk,
  input logic           rst_n,
  elastic_write_ctrl_if.slave eb
);

  localparam int unsigned AW = $clog2(BUFFER_DEPTH);
  localparam int unsigned PW = AW + 1;

  eb_os_state_e  state_q, state_d;
  logic [PW-1:0] write_address_q, write_address_d;
  logic [PW-1:0] fill_level_q, fill_level_d;
  logic          overflow_q, overflow_d;
  logic          skp_removed_q, skp_removed_d;
  logic          skp_added_q, skp_added_d;

  logic [PW-1:0] gray_wr_c;
  logic [PW-1:0] rd_bin_c;
  logic          full_c;
  logic          accept_c;
  logic          drop_c;
  logic          write_en_c;
  logic          is_com_c;
  logic          is_skp_c;
  logic          del_cond_c;

  eb_bin2gray #(.W(PW)) u_wr_gray (
    .bin_i  (write_address_q),
    .gray_o (gray_wr_c)
  );

  assign rd_bin_c = PW'(gray2bin(EB_PTR_MAX_W'(eb.gray_read_pointer)));

  // Full when the write pointer is exactly one lap (BUFFER_DEPTH) ahead.
  assign full_c = (gray_wr_c == {~eb.gray_read_pointer[AW -: 2],
                                 eb.gray_read_pointer[AW-2:0]});

  assign is_com_c = (eb.data_in == COM_P) || (eb.data_in == COM_N);
  assign is_skp_c = (eb.data_in == SKP_P) || (eb.data_in == SKP_N);

`ifdef EB_AUTO_DELETE_EN
  assign del_cond_c = (fill_level_q >= PW'(HIGH_WM));
`else
  assign del_cond_c = eb.delete_req;
`endif

  // Symbols discarded by overflow do not advance the ordered-set tracking.
  assign accept_c = eb.data_valid & ~full_c;

  // Ordered-set FSM: next state and SKP drop decision.
  always_comb begin
    state_d = state_q;
    drop_c  = 1'b0;
    if (accept_c) begin
      if (is_com_c) begin
        state_d = OS_OPEN;
      end else if (is_skp_c) begin
        if ((state_q == OS_OPEN) && del_cond_c) begin
          drop_c  = 1'b1;
          state_d = OS_DONE;
        end
      end else begin
        state_d = NORMAL;
      end
    end
  end

  assign write_en_c = accept_c & ~drop_c;

  // Next values of the registered outputs.
  always_comb begin
    write_address_d = write_address_q + PW'(write_en_c);
    fill_level_d    = write_address_q - rd_bin_c;
    skp_removed_d   = drop_c;
    skp_added_d     = write_en_c & is_skp_c & (fill_level_q < PW'(LOW_WM));
    overflow_d      = overflow_q;
    if (eb.data_valid && full_c) begin
      overflow_d = 1'b1;
    end else if (eb.overflow_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge write_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= NORMAL;
      write_address_q <= '0;
      fill_level_q    <= '0;
      overflow_q      <= 1'b0;
      skp_removed_q   <= 1'b0;
      skp_added_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      write_address_q <= write_address_d;
      fill_level_q    <= fill_level_d;
      overflow_q      <= overflow_d;
      skp_removed_q   <= skp_removed_d;
      skp_added_q     <= skp_added_d;
    end
  end

  assign eb.write_en           = write_en_c;
  assign eb.full               = full_c;
  assign eb.gray_write_pointer = gray_wr_c;
  assign eb.write_address      = write_address_q;
  assign eb.fill_level         = fill_level_q;
  assign eb.overflow           = overflow_q;
  assign eb.skp_removed        = skp_removed_q;
  assign eb.skp_added          = skp_added_q;

endmodule
